// File: rtl/obstacle_timer_sched.sv
// obstacle_timer_sched
// ---------------------------------------------------------------------------
// Scheduler/arbiter for the shared loadable down counter that times obstacle
// gaps. Two requesters (0 = ground, 1 = air) ask for a countdown; the block
// grants round-robin, loads the counter, waits for it to reach zero and
// reports completion with the winner's ID. It is the only driver of the
// counter's load_en/data and never resets the counter itself.
//
// Ports
//   clk, rst_n     : clock, synchronous active-low reset
//   req[1:0]       : level requests, bit i = requester i
//   req_val0/1     : countdown length per requester (sampled at arbitration)
//   abort          : cancel the countdown in progress (honoured in RUN only)
//   gnt[1:0]       : one-hot, one-cycle grant pulse (coincides with load)
//   busy           : high whenever the FSM is not IDLE
//   done, done_id  : one-cycle completion pulse and winner ID
//   cnt_load_en    : counter load enable
//   cnt_data       : counter load value
//   cnt_out        : counter current value
//   err            : (only with OBST_TIMER_SCHED_CHECK_EN) sticky flag set
//                    when cnt_out departs from the expected countdown
//
// Optional feature macro: OBST_TIMER_SCHED_CHECK_EN
//
// Handshake: req is a level; the requester drops it on seeing its gnt bit.
// A req still high when the FSM returns to IDLE counts as a new request.
// All outputs are registered.
// ---------------------------------------------------------------------------
module obstacle_timer_sched #(
    parameter int BITS = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req,
    input  logic [BITS-1:0] req_val0,
    input  logic [BITS-1:0] req_val1,
    input  logic            abort,
    output logic [1:0]      gnt,
    output logic            busy,
    output logic            done,
    output logic            done_id,
    output logic            cnt_load_en,
    output logic [BITS-1:0] cnt_data,
    input  logic [BITS-1:0] cnt_out
`ifdef OBST_TIMER_SCHED_CHECK_EN
    ,
    output logic            err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q;
    logic            rr_last_q;
    logic            winner_q;
    logic [1:0]      gnt_q;
    logic            busy_q;
    logic            done_q;
    logic            done_id_q;
    logic            cnt_load_en_q;
    logic [BITS-1:0] cnt_data_q;

    logic            winner_d;
    logic [BITS-1:0] val_d;

`ifdef OBST_TIMER_SCHED_CHECK_EN
    logic [BITS-1:0] exp_q;
    logic            err_q;
`endif

    // Arbitration: a lone requester wins; on a tie the one that did not win
    // last time goes first.
    always_comb begin
        winner_d = 1'b0;
        case (req)
            2'b01:   winner_d = 1'b0;
            2'b10:   winner_d = 1'b1;
            2'b11:   winner_d = ~rr_last_q;
            default: winner_d = 1'b0;
        endcase
        val_d = winner_d ? req_val1 : req_val0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rr_last_q     <= 1'b1;
            winner_q      <= 1'b0;
            gnt_q         <= 2'b00;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            done_id_q     <= 1'b0;
            cnt_load_en_q <= 1'b0;
            cnt_data_q    <= '0;
`ifdef OBST_TIMER_SCHED_CHECK_EN
            exp_q         <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low; each state raises what it needs.
            gnt_q         <= 2'b00;
            done_q        <= 1'b0;
            cnt_load_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req != 2'b00) begin
                        state_q       <= LOAD;
                        winner_q      <= winner_d;
                        rr_last_q     <= winner_d;
                        cnt_data_q    <= val_d;
                        gnt_q         <= {winner_d, ~winner_d};
                        cnt_load_en_q <= 1'b1;
                        busy_q        <= 1'b1;
                    end
                end
                LOAD: begin
                    state_q <= RUN;
`ifdef OBST_TIMER_SCHED_CHECK_EN
                    exp_q   <= cnt_data_q;
`endif
                end
                RUN: begin
`ifdef OBST_TIMER_SCHED_CHECK_EN
                    exp_q <= exp_q - BITS'(1);
`endif
                    if (abort) begin
                        // Abort beats a simultaneous zero: no done pulse.
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
`ifdef OBST_TIMER_SCHED_CHECK_EN
                    end else if (cnt_out != exp_q) begin
                        // Counter diverged from the loaded countdown.
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
`endif
                    end else if (cnt_out == '0) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        done_id_q <= winner_q;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt         = gnt_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign done_id     = done_id_q;
    assign cnt_load_en = cnt_load_en_q;
    assign cnt_data    = cnt_data_q;
`ifdef OBST_TIMER_SCHED_CHECK_EN
    assign err         = err_q;
`endif

endmodule
